// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM states, decoded memory ops and the op priority encoder.
package mem_stage_pkg;

    typedef enum logic [1:0] {IDLE, WAIT1, WAIT2} mem_state_t;

    typedef enum logic [2:0] {NONE, RD, WR, PUSH, POP, PUSH_PC, POP_PC} mem_op_t;

    // Priority: pop_pc > push_pc > pop > push > read > write.
    function automatic mem_op_t op_decode(input logic pop_pc, input logic push_pc,
                                          input logic pop, input logic push,
                                          input logic rd, input logic wr);
        if (pop_pc)       return POP_PC;
        else if (push_pc) return PUSH_PC;
        else if (pop)     return POP;
        else if (push)    return PUSH;
        else if (rd)      return RD;
        else if (wr)      return WR;
        else              return NONE;
    endfunction

    function automatic logic is_pc_op(input mem_op_t op);
        return (op == PUSH_PC) || (op == POP_PC);
    endfunction

endpackage

// File: rtl/stack_pointer_unit.sv
// Stack pointer register: steps by 1 or 2 on commit, wraps modulo 2**ADDR_W.
module stack_pointer_unit #(
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit,
    input  logic              dec,
    input  logic              two,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_p1,
    output logic [ADDR_W-1:0] sp_p2,
    output logic [ADDR_W-1:0] sp_m1
);

    logic [ADDR_W-1:0] step;

    assign step  = {{(ADDR_W-2){1'b0}}, two, ~two};
    assign sp_p1 = sp + ADDR_W'(1);
    assign sp_p2 = sp + ADDR_W'(2);
    assign sp_m1 = sp - ADDR_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      sp <= SP_INIT;
        else if (commit) sp <= dec ? (sp - step) : (sp + step);
    end

endmodule

// File: rtl/memory_stage_hs.sv
// MEM stage: ready/req data-memory access with wait states, stack push/pop, two-word PC
// push/pop, upstream stall and a registered MEM/WB entry.
module memory_stage_hs
    import mem_stage_pkg::*;
#(
    parameter int                DATA_W  = 16,
    parameter int                ADDR_W  = 16,
    parameter int                PC_W    = 32,
    parameter int                RA_W    = 3,
    parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              memory_read,
    input  logic              memory_write,
    input  logic              memory_push,
    input  logic              memory_pop,
    input  logic              push_pc,
    input  logic              pop_pc,
    input  logic [ADDR_W-1:0] std_address,
    input  logic [ADDR_W-1:0] ldd_address,
    input  logic [DATA_W-1:0] store_data,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] alu_value,
    input  logic              reg_write,
    input  logic [1:0]        wb_sel,
    input  logic [RA_W-1:0]   reg_write_address,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_r,
    output logic [PC_W-1:0]   final_pc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] sp,
    output logic [DATA_W-1:0] alu_value_out,
    output logic              reg_write_out,
    output logic [1:0]        wb_sel_out,
    output logic [RA_W-1:0]   reg_write_address_out
);

    localparam int PT_W = DATA_W + 1 + 2 + RA_W;

    mem_state_t        state, state_nxt;
    mem_op_t           op_in, op_q, op_cur;
    logic              idle, accept, req_act, word2, last, we_c, stall_c, complete, commit;
    logic              sp_commit;
    logic [ADDR_W-1:0] addr_q, rw_addr, addr_c, sp_p1, sp_p2, sp_m1;
    logic [DATA_W-1:0] wdata_q, st_cur, wdata_c, lo_q;
    logic [PC_W-1:0]   pc_q, pc_cur;
    logic [PT_W-1:0]   pt_q, pt_cur;

    assign idle    = (state == IDLE);
    assign op_in   = op_decode(pop_pc, push_pc, memory_pop, memory_push, memory_read, memory_write);
    assign accept  = idle & in_valid & ~flush;
    assign op_cur  = idle ? op_in : op_q;
    assign word2   = (state == WAIT2);
    assign req_act = ~idle | (accept & (op_in != NONE));
    assign last    = ~is_pc_op(op_cur) | word2;
    assign stall_c = req_act & ~(mem_ready & last);
    assign complete = idle ? (accept & ~stall_c) : (mem_ready & last);
    assign commit   = req_act & mem_ready & last;

    // In IDLE the request comes straight from the inputs; in WAIT states from the captured copy.
    assign rw_addr = idle ? ((op_in == RD) ? ldd_address : std_address) : addr_q;
    assign st_cur  = idle ? store_data : wdata_q;
    assign pc_cur  = idle ? pc : pc_q;
    assign pt_cur  = idle ? {alu_value, reg_write, wb_sel, reg_write_address} : pt_q;

    always_comb begin
        addr_c  = rw_addr;
        wdata_c = st_cur;
        we_c    = 1'b0;
        case (op_cur)
            WR:      we_c = 1'b1;
            PUSH:    begin addr_c = sp; we_c = 1'b1; end
            POP:     addr_c = sp_p1;
            PUSH_PC: begin
                addr_c  = word2 ? sp_m1 : sp;
                wdata_c = word2 ? pc_cur[DATA_W-1:0] : pc_cur[PC_W-1:DATA_W];
                we_c    = 1'b1;
            end
            POP_PC:  addr_c = word2 ? sp_p2 : sp_p1;
            default: ;
        endcase
    end

    // Reset gates the combinational outputs so mem_req drops the instant reset asserts.
    assign mem_req   = reset & req_act;
    assign mem_we    = mem_req & we_c;
    assign mem_addr  = mem_req ? addr_c : '0;
    assign mem_wdata = mem_we ? wdata_c : '0;
    assign stall     = reset & stall_c;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_act) state_nxt = mem_ready ? (is_pc_op(op_in) ? WAIT2 : IDLE) : WAIT1;
            WAIT1:   if (mem_ready) state_nxt = is_pc_op(op_q) ? WAIT2 : IDLE;
            WAIT2:   if (mem_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    assign sp_commit = commit & (op_cur inside {PUSH, POP, PUSH_PC, POP_PC});

    stack_pointer_unit #(.ADDR_W(ADDR_W), .SP_INIT(SP_INIT)) u_sp (
        .clk    (clk),
        .reset  (reset),
        .commit (sp_commit),
        .dec    ((op_cur == PUSH) || (op_cur == PUSH_PC)),
        .two    (is_pc_op(op_cur)),
        .sp     (sp),
        .sp_p1  (sp_p1),
        .sp_p2  (sp_p2),
        .sp_m1  (sp_m1)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            pt_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (idle) begin
                op_q    <= op_in;
                addr_q  <= rw_addr;
                wdata_q <= store_data;
                pc_q    <= pc;
                pt_q    <= pt_cur;
            end
            // First word of a PC pop is the low half.
            if (req_act & mem_ready & ~last) lo_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r                <= '0;
            final_pc              <= '0;
            pc_load               <= 1'b0;
            out_valid             <= 1'b0;
            alu_value_out         <= '0;
            reg_write_out         <= 1'b0;
            wb_sel_out            <= '0;
            reg_write_address_out <= '0;
        end else begin
            if (commit & ((op_cur == RD) | (op_cur == POP))) data_r <= mem_rdata;
            if (commit & (op_cur == POP_PC)) final_pc <= {mem_rdata, lo_q};
            pc_load       <= commit & (op_cur == POP_PC);
            out_valid     <= complete;
            reg_write_out <= complete & pt_cur[RA_W+2];
            if (complete) begin
                alu_value_out         <= pt_cur[PT_W-1 -: DATA_W];
                wb_sel_out            <= pt_cur[RA_W +: 2];
                reg_write_address_out <= pt_cur[RA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_memory_stage_hs.sv
// Random and directed bench for memory_stage_hs against a transaction-level stack/memory model.
module tb_memory_stage_hs;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, flush;
    logic        memory_read, memory_write, memory_push, memory_pop, push_pc, pop_pc;
    logic [15:0] std_address, ldd_address, store_data, alu_value;
    logic [31:0] pc;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  reg_write_address;
    logic        mem_req, mem_we, mem_ready, stall, out_valid, pc_load, reg_write_out;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, data_r, sp, alu_value_out;
    logic [31:0] final_pc;
    logic [1:0]  wb_sel_out;
    logic [2:0]  reg_write_address_out;

    memory_stage_hs dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
        .memory_read(memory_read), .memory_write(memory_write),
        .memory_push(memory_push), .memory_pop(memory_pop),
        .push_pc(push_pc), .pop_pc(pop_pc),
        .std_address(std_address), .ldd_address(ldd_address), .store_data(store_data), .pc(pc),
        .alu_value(alu_value), .reg_write(reg_write), .wb_sel(wb_sel),
        .reg_write_address(reg_write_address),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall), .out_valid(out_valid),
        .data_r(data_r), .final_pc(final_pc), .pc_load(pc_load), .sp(sp),
        .alu_value_out(alu_value_out), .reg_write_out(reg_write_out), .wb_sel_out(wb_sel_out),
        .reg_write_address_out(reg_write_address_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [15:0] a; logic we; logic [15:0] d;} acc_t;

    bit   [15:0] env_mem [0:65535];   // memory as seen by the DUT
    bit   [15:0] ref_mem [0:65535];   // memory as the model expects it
    acc_t        exp_q[$];
    logic [15:0] ref_sp, ref_data_r;
    logic [31:0] ref_fpc;
    int          n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; flush = 0;
        {pop_pc, push_pc, memory_pop, memory_push, memory_read, memory_write} = '0;
    endtask

    // ops = {pop_pc, push_pc, pop, push, read, write}; waits<0 gives random ready,
    // otherwise mem_ready stays low for 'waits' cycles before each word completes.
    task automatic do_instr(input logic [5:0] ops, input bit fl, input logic [15:0] la,
                            input logic [15:0] sa, input logic [15:0] sd,
                            input logic [31:0] pcv, input int waits);
        logic [15:0] a0, a1, a2, am1, f_a, f_d;
        logic        exp_pcl, exp_stall, done, fire, f_we;
        int          cyc, low;
        a0 = ref_sp; a1 = ref_sp + 16'd1; a2 = ref_sp + 16'd2; am1 = ref_sp - 16'd1;
        exp_pcl = 0;
        exp_q.delete();
        if (!fl) begin
            if (ops[5]) begin
                exp_q.push_back('{a: a1, we: 1'b0, d: 16'h0});
                exp_q.push_back('{a: a2, we: 1'b0, d: 16'h0});
                ref_fpc = {ref_mem[a2], ref_mem[a1]};
                ref_sp  = a2;
                exp_pcl = 1;
            end else if (ops[4]) begin
                exp_q.push_back('{a: a0, we: 1'b1, d: pcv[31:16]});
                exp_q.push_back('{a: am1, we: 1'b1, d: pcv[15:0]});
                ref_mem[a0] = pcv[31:16]; ref_mem[am1] = pcv[15:0];
                ref_sp = ref_sp - 16'd2;
            end else if (ops[3]) begin
                exp_q.push_back('{a: a1, we: 1'b0, d: 16'h0});
                ref_data_r = ref_mem[a1]; ref_sp = a1;
            end else if (ops[2]) begin
                exp_q.push_back('{a: a0, we: 1'b1, d: sd});
                ref_mem[a0] = sd; ref_sp = am1;
            end else if (ops[1]) begin
                exp_q.push_back('{a: la, we: 1'b0, d: 16'h0});
                ref_data_r = ref_mem[la];
            end else if (ops[0]) begin
                exp_q.push_back('{a: sa, we: 1'b1, d: sd});
                ref_mem[sa] = sd;
            end
        end
        in_valid = 1; flush = fl;
        {pop_pc, push_pc, memory_pop, memory_push, memory_read, memory_write} = ops;
        ldd_address = la; std_address = sa; store_data = sd; pc = pcv;
        alu_value = 16'($urandom); reg_write = 1'($urandom);
        wb_sel = 2'($urandom); reg_write_address = 3'($urandom);
        cyc = 0; low = 0; done = 0;
        while (!done) begin
            if (cyc >= 40) begin chk("timeout", 1, 0); break; end
            mem_ready = (waits < 0) ? ($urandom_range(0, 2) != 0) : (low >= waits);
            #1 mem_rdata = mem_req ? env_mem[mem_addr] : 16'($urandom);
            #1;
            chk("mem_req", mem_req, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("mem_addr", mem_addr, exp_q[0].a);
                chk("mem_we", mem_we, exp_q[0].we);
                if (exp_q[0].we) chk("mem_wdata", mem_wdata, exp_q[0].d);
            end
            exp_stall = (exp_q.size() > 1) || (exp_q.size() == 1 && !mem_ready);
            chk("stall", stall, exp_stall);
            fire = (exp_q.size() != 0) && mem_ready;
            f_a = mem_addr; f_d = mem_wdata; f_we = mem_we;
            @(posedge clk);
            if (fire) begin
                if (f_we) env_mem[f_a] = f_d;
                void'(exp_q.pop_front());
                low = 0;
            end else low++;
            done = !exp_stall;
            @(negedge clk);
            cyc++;
            chk("out_valid", out_valid, done && !fl);
            chk("reg_write_out", reg_write_out, (done && !fl) ? reg_write : 1'b0);
        end
        if (!fl) begin
            chk("alu_value_out", alu_value_out, alu_value);
            chk("wb_sel_out", wb_sel_out, wb_sel);
            chk("ra_out", reg_write_address_out, reg_write_address);
        end
        chk("data_r", data_r, ref_data_r);
        chk("sp", sp, ref_sp);
        chk("pc_load", pc_load, exp_pcl);
        if (exp_pcl) chk("final_pc", final_pc, ref_fpc);
        idle_inputs();
        mem_ready = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        chk("pc_load_gap", pc_load, 0);
        chk("out_valid_gap", out_valid, 0);
        chk("mem_req_gap", mem_req, 0);
    endtask

    initial begin
        reset = 0; idle_inputs(); mem_ready = 0; mem_rdata = 0;
        ldd_address = 0; std_address = 0; store_data = 0; pc = 0;
        alu_value = 0; reg_write = 0; wb_sel = 0; reg_write_address = 0;
        ref_sp = 16'hFFFF; ref_data_r = 0; ref_fpc = 0;
        env_mem[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_sp", sp, 16'hFFFF);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_r", data_r, 0);
        reset = 1;
        @(negedge clk);

        // Reset in the middle of a waited store.
        in_valid = 1; memory_write = 1; std_address = 16'h0040; store_data = 16'h5555;
        mem_ready = 0;
        @(posedge clk); @(negedge clk);
        #1 chk("wait1_req", mem_req, 1);
        reset = 0;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_sp", sp, 16'hFFFF);
        chk("async_out_valid", out_valid, 0);
        chk("async_stall", stall, 0);
        @(negedge clk);
        idle_inputs(); reset = 1;
        @(negedge clk);

        do_instr(6'b000010, 0, 16'h0010, 16'h0, 16'h0, 32'h0, 0);             // LDD, zero wait
        do_instr(6'b000001, 0, 16'h0, 16'h0020, 16'h1234, 32'h0, 3);          // STD, 3 waits
        chk("std_mem", env_mem[16'h0020], 16'h1234);
        do_instr(6'b010000, 0, 16'h0, 16'h0, 16'h0, 32'h0001_0ABC, 0);        // PUSH_PC
        chk("pushpc_hi", env_mem[16'hFFFF], 16'h0001);
        chk("pushpc_lo", env_mem[16'hFFFE], 16'h0ABC);
        do_instr(6'b100000, 0, 16'h0, 16'h0, 16'h0, 32'h0, 0);                // POP_PC
        do_instr(6'b001000, 0, 16'h0, 16'h0, 16'h0, 32'h0, 0);                // pop with SP wrap
        chk("wrap_sp", sp, 16'h0000);
        do_instr(6'b000001, 1, 16'h0, 16'h0030, 16'h7777, 32'h0, 0);          // flushed store
        do_instr(6'b001100, 0, 16'h0, 16'h0, 16'hAAAA, 32'h0, 1);             // push & pop -> pop
        do_instr(6'b000000, 0, 16'h0, 16'h0, 16'h0, 32'h0, 0);                // non-memory op

        for (int i = 0; i < 400; i++) begin
            logic [5:0] ops;
            for (int b = 0; b < 6; b++) ops[b] = ($urandom_range(0, 4) == 0);
            do_instr(ops, $urandom_range(0, 9) == 0,
                     16'($urandom_range(0, 31)), 16'($urandom_range(0, 31)),
                     16'($urandom), $urandom,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
